// File: rtl/mem_io_responder_if.sv
// CPU-side byte bus of the memory/IO responder: address, write strobe,
// write data, registered read data and the TX almost-full back-pressure flag.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (output mem_a, mem_wr, mem_dout, input mem_din, io_buffer_full);
  modport slave  (input mem_a, mem_wr, mem_dout, output mem_din, io_buffer_full);
endinterface

// File: rtl/mem_io_responder.sv
// Target side of the CPU byte bus: un-reset RAM array plus an IO window at
// 0x3xxxx with UART RX pop, TX FIFO push, cycle-counter snapshot and program stop.
module mem_io_responder #(
  parameter int RAM_ADDR_W    = 17,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int FULL_MARGIN   = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  mem_io_responder_if.slave   bus,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                program_stop,
  output logic                tx_overflow
);
  localparam int DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int FULL_TH_I = DEPTH - FULL_MARGIN;
  localparam logic [TX_DEPTH_LOG2:0] DEPTH_C   = DEPTH[TX_DEPTH_LOG2:0];
  localparam logic [TX_DEPTH_LOG2:0] FULL_TH_C = FULL_TH_I[TX_DEPTH_LOG2:0];

  localparam logic [17:0] A_RX_TX = 18'h30000;
  localparam logic [17:0] A_CNT0  = 18'h30004;
  localparam logic [17:0] A_CNT1  = 18'h30005;
  localparam logic [17:0] A_CNT2  = 18'h30006;
  localparam logic [17:0] A_CNT3  = 18'h30007;

  logic [17:0] a;
  logic        wr, is_io, ram_we, io_rd;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic        unused_addr_hi;

  assign a              = bus.mem_a[17:0];
  assign wr             = bus.mem_wr;
  assign is_io          = (a[17:16] == 2'b11);
  assign ram_idx        = bus.mem_a[RAM_ADDR_W-1:0];
  assign ram_we         = !is_io && wr;
  assign io_rd          = is_io && !wr;
  assign unused_addr_hi = ^bus.mem_a[31:18];

  // RAM kept free of reset so it maps onto block RAM; the reset-able select
  // register below forces mem_din to 0 while rst_in is high.
  logic [7:0] ram [2**RAM_ADDR_W];
  logic [7:0] ram_q;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= bus.mem_dout;
    ram_q <= ram[ram_idx];
  end

  logic [31:0] counter, snapshot;
  logic        sel_ram;
  logic [7:0]  io_q, io_next;

  always_comb begin
    io_next = 8'h00;
    if (io_rd) begin
      case (a)
        A_RX_TX: io_next = rx_valid ? rx_data : 8'h00;
        A_CNT0:  io_next = counter[7:0];
        A_CNT1:  io_next = snapshot[15:8];
        A_CNT2:  io_next = snapshot[23:16];
        A_CNT3:  io_next = snapshot[31:24];
        default: io_next = 8'h00;
      endcase
    end
  end

  assign bus.mem_din = sel_ram ? ram_q : io_q;
  assign rx_ready    = !rst_in && io_rd && (a == A_RX_TX) && rx_valid;

  // TX FIFO
  logic [7:0]               fifo [DEPTH];
  logic [TX_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TX_DEPTH_LOG2:0]   count;
  logic                     push_req, full, pop, accept;
  logic [7:0]               push_data;

  assign push_req  = is_io && wr && (((a == A_RX_TX) && (bus.mem_dout != 8'h00)) || (a == A_CNT0));
  assign push_data = (a == A_CNT0) ? 8'h00 : bus.mem_dout;
  assign full      = (count == DEPTH_C);
  assign tx_valid  = (count != '0);
  assign tx_data   = fifo[rd_ptr];
  assign pop       = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept    = push_req && (!full || pop);
  assign bus.io_buffer_full = (count >= FULL_TH_C);

  always_ff @(posedge clk_in) begin
    if (accept) fifo[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sel_ram      <= 1'b0;
      io_q         <= 8'h00;
      counter      <= '0;
      snapshot     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      program_stop <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      sel_ram <= !is_io && !wr;
      io_q    <= io_next;
      counter <= counter + 32'd1;
      if (io_rd && (a == A_CNT0)) snapshot <= counter;
      if (is_io && wr && (a == A_CNT0)) program_stop <= 1'b1;
      if (push_req && !accept) tx_overflow <= 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
